// File: rtl/axi_mem_test_master.sv
// AXI4 128-bit test initiator for the IRAM slave port. It writes num_bursts INCR bursts
// of an address-keyed pattern, then reads them back and compares. One transaction is outstanding at a time.
module axi_mem_test_master #(
  parameter int unsigned BEATS = 4,
  parameter logic [31:0] SEED  = 32'h5A5A_1234
) (
  input  logic         pll_core_cpuclk,
  input  logic         pad_cpu_rst_b,
  input  logic         start,
  input  logic [39:0]  base_addr,
  input  logic [7:0]   num_bursts,
  output logic         busy,
  output logic         done,
  output logic         fail,
  output logic [39:0]  awaddr_m0,
  output logic [7:0]   awlen_m0,
  output logic         awvalid_m0,
  input  logic         awready_m0,
  output logic [127:0] wdata_m0,
  output logic [15:0]  wstrb_m0,
  output logic         wlast_m0,
  output logic         wvalid_m0,
  input  logic         wready_m0,
  input  logic [1:0]   bresp_m0,
  input  logic         bvalid_m0,
  output logic         bready_m0,
  output logic [39:0]  araddr_m0,
  output logic [7:0]   arlen_m0,
  output logic         arvalid_m0,
  input  logic         arready_m0,
  input  logic [127:0] rdata_m0,
  input  logic [1:0]   rresp_m0,
  input  logic         rlast_m0,
  input  logic         rvalid_m0,
  output logic         rready_m0
);

  localparam logic [39:0] BURST_STEP = 40'(BEATS * 16);
  localparam logic [39:0] ALIGN_MASK = ~(BURST_STEP - 40'd1);
  localparam logic [7:0]  LAST_BEAT  = 8'(BEATS - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t      state, state_nx;
  logic [39:0] base, addr, beat_addr;
  logic [7:0]  count, burst, beat;
  logic        fail_q, last_beat, last_burst;

  function automatic logic [127:0] pattern(input logic [39:0] a);
    logic [31:0] w;
    w = a[31:0] ^ SEED;
    return {4{w}};
  endfunction

  // Alignment keeps each burst inside one 4KB page, so the beat offset never carries out of the low 12 bits.
  assign beat_addr  = addr + {28'd0, beat, 4'd0};
  assign last_beat  = (beat == LAST_BEAT);
  assign last_burst = (burst == count - 8'd1);

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) state <= S_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    done       = 1'b0;
    awvalid_m0 = 1'b0;
    wvalid_m0  = 1'b0;
    bready_m0  = 1'b0;
    arvalid_m0 = 1'b0;
    rready_m0  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = (num_bursts != 8'd0) ? S_AW : S_DONE;
      end
      S_AW: begin
        awvalid_m0 = 1'b1;
        if (awready_m0) state_nx = S_W;
      end
      S_W: begin
        wvalid_m0 = 1'b1;
        if (wready_m0 && last_beat) state_nx = S_B;
      end
      S_B: begin
        bready_m0 = 1'b1;
        if (bvalid_m0) state_nx = last_burst ? S_AR : S_AW;
      end
      S_AR: begin
        arvalid_m0 = 1'b1;
        if (arready_m0) state_nx = S_R;
      end
      S_R: begin
        rready_m0 = 1'b1;
        if (rvalid_m0 && last_beat) state_nx = last_burst ? S_DONE : S_AR;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      base   <= '0;
      addr   <= '0;
      count  <= '0;
      burst  <= '0;
      beat   <= '0;
      fail_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          fail_q <= 1'b0;
          if (num_bursts != 8'd0) begin
            base  <= base_addr & ALIGN_MASK;
            addr  <= base_addr & ALIGN_MASK;
            count <= num_bursts;
            burst <= '0;
          end
        end
        S_AW, S_AR: beat <= '0;
        S_W: if (wready_m0) beat <= beat + 8'd1;
        S_B: if (bvalid_m0) begin
          if (bresp_m0 != 2'b00) fail_q <= 1'b1;
          // Read phase restarts from the first burst.
          if (last_burst) begin
            addr  <= base;
            burst <= '0;
          end else begin
            addr  <= addr + BURST_STEP;
            burst <= burst + 8'd1;
          end
        end
        S_R: if (rvalid_m0) begin
          if (rdata_m0 != pattern(beat_addr) || rresp_m0 != 2'b00 || rlast_m0 != last_beat)
            fail_q <= 1'b1;
          beat <= beat + 8'd1;
          if (last_beat) begin
            addr  <= addr + BURST_STEP;
            burst <= burst + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fail      = fail_q;
  assign awaddr_m0 = awvalid_m0 ? addr : '0;
  assign awlen_m0  = awvalid_m0 ? LAST_BEAT : '0;
  assign araddr_m0 = arvalid_m0 ? addr : '0;
  assign arlen_m0  = arvalid_m0 ? LAST_BEAT : '0;
  assign wdata_m0  = wvalid_m0 ? pattern(beat_addr) : '0;
  assign wstrb_m0  = wvalid_m0 ? '1 : '0;
  assign wlast_m0  = wvalid_m0 & last_beat;

endmodule
